// File: rtl/heat_pixel_writer.sv
// Scans a row of column node values into RGB332 pixel writes and paces the column
// array with a start pulse once every active column has its row value ready.
module heat_pixel_writer #(
    parameter int unsigned NUM_COLS = 16,
    parameter int unsigned X_OFFSET = 0,
    parameter int unsigned Y_OFFSET = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic [7:0]               width,
    input  logic [7:0]               height,
    input  logic [NUM_COLS-1:0]      flags,
    input  logic [NUM_COLS*32-1:0]   node_bus,
    output logic                     start,
    output logic                     pix_req,
    output logic [9:0]               pix_x,
    output logic [9:0]               pix_y,
    output logic [7:0]               pix_color,
    input  logic                     pix_ack,
    output logic [7:0]               row_idx,
    output logic [15:0]              frame_cnt
);

    localparam int unsigned CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    typedef enum logic [2:0] {
        StWait,
        StCapture,
        StStart,
        StWrite,
        StAdvance
    } state_e;

    state_e      state_q;
    logic        start_q;
    logic        pix_req_q;
    logic [9:0]  pix_x_q;
    logic [9:0]  pix_y_q;
    logic [7:0]  pix_color_q;
    logic [7:0]  row_idx_q;
    logic [15:0] frame_cnt_q;
    logic [7:0]  row_q;
    logic [7:0]  col_q;
    logic [31:0] shadow_q [NUM_COLS];

    logic [7:0]  n_cols_d;
    logic [7:0]  last_col_d;
    logic [7:0]  col_nxt_d;
    logic        flags_ok_d;

    // s4.27 value to RGB332: positive heat in red, negative heat in blue.
    function automatic logic [7:0] color_map(input logic [31:0] v);
        logic [2:0]  r;
        logic [1:0]  b;
        logic [31:0] m;
        r = 3'd0;
        b = 2'd0;
        if (!v[31]) begin
            r = (v[31:27] > 5'd7) ? 3'd7 : v[30:28];
        end else begin
            m = (v == 32'h8000_0000) ? 32'h7FFF_FFFF : (~v + 32'd1);
            b = (m >= 32'h2000_0000) ? 2'd3 : m[29:28];
        end
        return {r, 3'b000, b};
    endfunction

    always_comb begin
        n_cols_d = width;
        if (width == 8'd0 || 32'(width) > NUM_COLS) begin
            n_cols_d = 8'(NUM_COLS);
        end
        last_col_d = n_cols_d - 8'd1;
        col_nxt_d  = col_q + 8'd1;
        flags_ok_d = 1'b1;
        for (int i = 0; i < int'(NUM_COLS); i++) begin
            if (i < int'(n_cols_d) && !flags[i]) begin
                flags_ok_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StWait;
            start_q     <= 1'b0;
            pix_req_q   <= 1'b0;
            pix_x_q     <= 10'd0;
            pix_y_q     <= 10'd0;
            pix_color_q <= 8'd0;
            row_idx_q   <= 8'd0;
            frame_cnt_q <= 16'd0;
            row_q       <= 8'd0;
            col_q       <= 8'd0;
            for (int i = 0; i < int'(NUM_COLS); i++) begin
                shadow_q[i] <= 32'd0;
            end
        end else begin
            unique case (state_q)
                StWait: begin
                    if (run && flags_ok_d) begin
                        state_q <= StCapture;
                    end
                end
                StCapture: begin
                    for (int i = 0; i < int'(NUM_COLS); i++) begin
                        if (i < int'(n_cols_d)) begin
                            shadow_q[i] <= node_bus[32*i +: 32];
                        end
                    end
                    row_idx_q <= row_q;
                    start_q   <= 1'b1;
                    state_q   <= StStart;
                end
                StStart: begin
                    start_q     <= 1'b0;
                    col_q       <= 8'd0;
                    pix_req_q   <= 1'b1;
                    pix_x_q     <= 10'(X_OFFSET);
                    pix_y_q     <= 10'(Y_OFFSET) + 10'(row_idx_q);
                    pix_color_q <= color_map(shadow_q[0]);
                    state_q     <= StWrite;
                end
                StWrite: begin
                    if (pix_ack) begin
                        // >= guards against width shrinking while a row is in flight.
                        if (col_q >= last_col_d) begin
                            pix_req_q <= 1'b0;
                            state_q   <= StAdvance;
                        end else begin
                            col_q       <= col_nxt_d;
                            pix_x_q     <= 10'(X_OFFSET) + 10'(col_nxt_d);
                            pix_color_q <= color_map(shadow_q[col_nxt_d[CW-1:0]]);
                        end
                    end
                end
                StAdvance: begin
                    if (row_q == height) begin
                        row_q       <= 8'd0;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end else begin
                        row_q <= row_q + 8'd1;
                    end
                    state_q <= StWait;
                end
                default: state_q <= StWait;
            endcase
        end
    end

    assign start     = start_q;
    assign pix_req   = pix_req_q;
    assign pix_x     = pix_x_q;
    assign pix_y     = pix_y_q;
    assign pix_color = pix_color_q;
    assign row_idx   = row_idx_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_heat_pixel_writer.sv
// Scoreboard bench for heat_pixel_writer with four columns: expected pixels are queued
// at stimulus time and a negedge monitor checks each accepted write against the queue.
module tb_heat_pixel_writer;

    logic         clk;
    logic         reset;
    logic         run;
    logic [7:0]   width;
    logic [7:0]   height;
    logic [3:0]   flags;
    logic [127:0] node_bus;
    logic         start;
    logic         pix_req;
    logic [9:0]   pix_x;
    logic [9:0]   pix_y;
    logic [7:0]   pix_color;
    logic         pix_ack;
    logic [7:0]   row_idx;
    logic [15:0]  frame_cnt;

    int tests     = 0;
    int fails     = 0;
    int pix_cnt   = 0;
    int start_cnt = 0;
    int rows      = 0;

    logic [27:0] sb[$];
    logic [7:0]  exp_c [4];

    heat_pixel_writer #(.NUM_COLS(4), .X_OFFSET(0), .Y_OFFSET(0)) dut (
        .clk       (clk),
        .reset     (reset),
        .run       (run),
        .width     (width),
        .height    (height),
        .flags     (flags),
        .node_bus  (node_bus),
        .start     (start),
        .pix_req   (pix_req),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_color (pix_color),
        .pix_ack   (pix_ack),
        .row_idx   (row_idx),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a write is accepted on the edge following a negedge with req and ack high.
    always @(negedge clk) begin
        if (!reset && start) start_cnt++;
        if (!reset && pix_req && pix_ack) begin
            pix_cnt++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pixel: got x=%0d y=%0d c=%0h, expected none",
                         pix_x, pix_y, pix_color);
            end else begin
                check("pixel", {4'h0, pix_x, pix_y, pix_color}, {4'h0, sb.pop_front()});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic [31:0] a, b, c, d, input logic [7:0] ca, cb, cc, cd);
        node_bus = {d, c, b, a};
        exp_c[0] = ca;
        exp_c[1] = cb;
        exp_c[2] = cc;
        exp_c[3] = cd;
    endtask

    task automatic begin_row(input int n, input int y, input logic [3:0] fl);
        int k;
        for (int i = 0; i < n; i++) sb.push_back({10'(i), 10'(y), exp_c[i]});
        flags = fl;
        k = 0;
        do begin
            step(1);
            k++;
        end while (!start && k < 20);
        check("start_latency", k, 2);
        check("row_idx", {24'h0, row_idx}, y);
        rows++;
        flags = 4'h0;
    endtask

    task automatic end_row(input int target, input int exp_k);
        int k;
        k = 0;
        while (pix_cnt < target && k < 200) begin
            step(1);
            k++;
        end
        if (pix_cnt < target) check("row_timeout", pix_cnt, target);
        if (exp_k > 0) check("row_cycles", k, exp_k);
        step(2);
        check("req_idle", {31'h0, pix_req}, 0);
        check("start_count", start_cnt, rows);
    endtask

    initial begin
        int target;
        reset    = 1'b1;
        run      = 1'b1;
        width    = 8'd4;
        height   = 8'd2;
        flags    = 4'h0;
        pix_ack  = 1'b1;
        node_bus = '0;
        step(2);
        check("rst_start", {31'h0, start}, 0);
        check("rst_req", {31'h0, pix_req}, 0);
        check("rst_xy", {12'h0, pix_x, pix_y}, 0);
        check("rst_color", {24'h0, pix_color}, 0);
        check("rst_row_frame", {8'h0, row_idx, frame_cnt}, 0);
        reset = 1'b0;

        // Row A: partial flags must not start; then one pixel per clock.
        set_bus(32'h4000_0000, 32'h1000_0000, 32'hC000_0000, 32'h0000_0000,
                8'hE0, 8'h20, 8'h03, 8'h00);
        flags = 4'b0111;
        step(10);
        check("no_start_partial", start_cnt, 0);
        target = pix_cnt + 4;
        begin_row(4, 0, 4'hF);
        end_row(target, 5);

        // Rows B and C complete the first frame.
        set_bus(32'h7FFF_FFFF, 32'h8000_0000, 32'hF000_0000, 32'h0800_0000,
                8'hE0, 8'h03, 8'h01, 8'h00);
        target = pix_cnt + 4;
        begin_row(4, 1, 4'hF);
        end_row(target, 5);
        set_bus(32'h3800_0000, 32'h2800_0000, 32'hE000_0000, 32'hFFFF_FFFF,
                8'h60, 8'h40, 8'h03, 8'h00);
        target = pix_cnt + 4;
        begin_row(4, 2, 4'hF);
        end_row(target, 5);
        check("frame_cnt_1", {16'h0, frame_cnt}, 1);

        // Row D: stall on column 1 while the bus churns.
        set_bus(32'h4000_0000, 32'h1000_0000, 32'hC000_0000, 32'h0000_0000,
                8'hE0, 8'h20, 8'h03, 8'h00);
        pix_ack = 1'b0;
        target = pix_cnt + 4;
        begin_row(4, 0, 4'hF);
        step(1);
        pix_ack = 1'b1;
        step(1);
        pix_ack = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("stall_req", {31'h0, pix_req}, 1);
            check("stall_x", {22'h0, pix_x}, 1);
            check("stall_color", {24'h0, pix_color}, exp_c[1]);
            node_bus = ~node_bus;
            step(1);
        end
        pix_ack = 1'b1;
        end_row(target, 0);

        // Row E: width 0 means all columns; row F: width 2 gates on flags[1:0] only.
        width = 8'd0;
        set_bus(32'h7FFF_FFFF, 32'h8000_0000, 32'hF000_0000, 32'h0800_0000,
                8'hE0, 8'h03, 8'h01, 8'h00);
        target = pix_cnt + 4;
        begin_row(4, 1, 4'hF);
        end_row(target, 5);
        width = 8'd2;
        target = pix_cnt + 2;
        begin_row(2, 2, 4'b0011);
        end_row(target, 3);
        check("frame_cnt_2", {16'h0, frame_cnt}, 2);
        width = 8'd4;

        // Row G at y=0, then row H is cut by reset at column 2.
        target = pix_cnt + 4;
        begin_row(4, 0, 4'hF);
        end_row(target, 5);
        begin_row(4, 1, 4'hF);
        step(3);
        pix_ack = 1'b0;
        check("pre_rst_x", {22'h0, pix_x}, 2);
        check("pre_rst_req", {31'h0, pix_req}, 1);
        reset = 1'b1;
        #1;
        check("async_req", {31'h0, pix_req}, 0);
        check("async_xy", {12'h0, pix_x, pix_y}, 0);
        check("async_color", {24'h0, pix_color}, 0);
        check("async_frame", {16'h0, frame_cnt}, 0);
        sb.delete();
        step(2);
        reset   = 1'b0;
        pix_ack = 1'b1;
        step(4);
        check("post_rst_no_start", start_cnt, rows);
        check("post_rst_req", {31'h0, pix_req}, 0);
        target = pix_cnt + 4;
        begin_row(4, 0, 4'hF);
        end_row(target, 5);
        check("post_rst_frame", {16'h0, frame_cnt}, 0);
        check("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/heat_pixel_writer.md
HEAT_PIXEL_WRITER -- requirements
Module: heat_pixel_writer

Interface
REQ-001 Parameter NUM_COLS, default 16: number of column ports on the node bus.
REQ-002 Parameter X_OFFSET, default 0: added to column index to form pixel x.
REQ-003 Parameter Y_OFFSET, default 0: added to row index to form pixel y.
REQ-004 clk  input  1  system clock (CLOCK_50); all logic in this one clock domain.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 run  input  1  level enable; when low, no new start pulse is issued.
REQ-007 width  input  8  number of active columns.
REQ-008 height  input  8  top row index; rows run 0..height inclusive.
REQ-009 flags  input  NUM_COLS  per-column "row value ready" flags; bit i from column i.
REQ-010 node_bus  input  NUM_COLS*32  column node values, signed s4.27; column i in bits [32i+31:32i].
REQ-011 start  output  1  single-cycle pulse releasing all columns to compute the next row.
REQ-012 pix_req  output  1  pixel write request.
REQ-013 pix_x  output  10  pixel x coordinate.
REQ-014 pix_y  output  10  pixel y coordinate.
REQ-015 pix_color  output  8  RGB332 pixel color.
REQ-016 pix_ack  input  1  pixel sink accepted the current request.
REQ-017 row_idx  output  8  row index of the most recently captured row.
REQ-018 frame_cnt  output  16  completed full-grid sweeps, wraps at 65535 to 0.

Function
REQ-019 Active column count N = width if 1 <= width <= NUM_COLS, else NUM_COLS; width = 0 forces N = NUM_COLS.
REQ-020 FSM states: WAIT, CAPTURE, START, WRITE, ADVANCE.
REQ-021 WAIT: go to CAPTURE on the first clock where flags[N-1:0] are all 1 and run = 1; otherwise stay. Flags above N are ignored.
REQ-022 CAPTURE, one cycle: latch node_bus for columns 0..N-1 into a shadow buffer, latch the row counter into row_idx, then go to START.
REQ-023 START, one cycle: drive start = 1, clear the column index to 0, then go to WRITE. start is 0 in every other state.
REQ-024 WRITE: hold pix_req = 1 with stable pix_x = X_OFFSET + col, pix_y = Y_OFFSET + row_idx, and pix_color = map(shadow[col]).
REQ-025 WRITE: on a clock with pix_ack = 1, either increment col and stay in WRITE, or go to ADVANCE if col = N-1.
REQ-026 WRITE: pix_req drops to 0 for at least one cycle between consecutive requests only when leaving WRITE; back-to-back acks give one pixel per clock.
REQ-027 ADVANCE, one cycle: if the row counter = height, set it to 0 and increment frame_cnt; else increment the row counter. Then go to WAIT.
REQ-028 The internal row counter tracks the columns' row sequence, which starts at row 0 after reset.
REQ-029 Color map, value v (s4.27), for v >= 0: R = v[30:28] saturated to 7 if v[31:27] > 7, G = 0, B = 0.
REQ-030 Color map, v < 0: magnitude m = -v, saturating at 0x7FFFFFFF for v = 0x80000000; B = m[29:28] saturated to 3 if m >= 4.0; R = G = 0.
REQ-031 pix_color = {R[2:0], G[2:0], B[1:0]}.
REQ-032 Shadow data changes only in CAPTURE; columns may change node_bus freely after start.
REQ-033 A flags change during WRITE or ADVANCE has no effect until WAIT is re-entered.
REQ-034 run deasserted mid-row: the current row's writes still complete; the FSM then holds in WAIT.
REQ-035 pix_ack while pix_req = 0 is ignored.

Reset
REQ-036 While reset = 1, asynchronously and immediately: state = WAIT, start = 0, pix_req = 0, pix_x = 0, pix_y = 0, pix_color = 0, row_idx = 0, frame_cnt = 0, row counter = 0, col = 0.
REQ-037 Reset asserted mid-WRITE abandons the outstanding request; no ack is awaited after release.
REQ-038 The first WAIT evaluation occurs on the first rising edge after reset deasserts.

Verification
REQ-039 NUM_COLS=4, width=4, run=1; flags 4'b0111 for 10 cycles, then 4'b1111 -> no start during the 10 cycles; start pulses exactly once, 2 cycles after all flags high.
REQ-040 node_bus col0=0x40000000 (8.0), col1=0x10000000 (2.0), col2=0xC0000000 (-8.0), col3=0; pix_ack tied 1 -> pix_color 0xE0, 0x20, 0x03, 0x00 on 4 consecutive cycles at x=0..3, y=0.
REQ-041 height=2, flags toggled 3 rows -> row_idx 0,1,2; after the third ADVANCE, row counter = 0 and frame_cnt = 1.
REQ-042 pix_ack held low 20 cycles on col 1 -> pix_req, pix_x=1, and pix_color stable throughout; node_bus changes during the stall do not alter pix_color.
REQ-043 width=0 with NUM_COLS=4 -> 4 writes per row; width=2 -> only flags[1:0] gate start, and only x=0,1 are written.
REQ-044 Reset asserted during WRITE at col 2 -> pix_req=0 and all outputs 0 within the same cycle; after release, the FSM waits for flags and y restarts at 0.
